// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multi-cycle control unit for the RV32I datapath.
// Steps each instruction through FETCH/DECODE/EXEC/MEM/WB and drives every
// datapath control input. Register writes, memory writes and PC loads are
// single-cycle registered pulses; static controls are decoded from the
// latched instruction word and held from DECODE through the retire cycle.
// Illegal opcodes either halt the unit or retire as a NOP, and every retired
// instruction is counted.
module mc_ctrl_fsm #(
    parameter int INSTRET_W       = 32,
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [31:0]          instr,
    input  logic                 BrEQ,
    input  logic                 BrLT,
    input  logic                 i_fetch_ack,
    output logic                 o_fetch_req,
    output logic                 o_pc_en,
    output logic                 PCSel,
    output logic [3:0]           ImmSel,
    output logic                 RegWen,
    output logic                 BrUn,
    output logic                 ASel,
    output logic                 BSel,
    output logic [1:0]           ALU_op,
    output logic                 LUI_Sel,
    output logic [3:0]           LoadType,
    output logic                 LoadSigned,
    output logic                 MemRW,
    output logic [1:0]           WBSel,
    output logic                 o_illegal,
    output logic [INSTRET_W-1:0] o_instret
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [3:0] IMM_I = 4'b0000;
    localparam logic [3:0] IMM_S = 4'b0001;
    localparam logic [3:0] IMM_B = 4'b0010;
    localparam logic [3:0] IMM_J = 4'b0100;
    localparam logic [3:0] IMM_U = 4'b1000;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_FUNCT = 2'b01;
    localparam logic [1:0] ALU_PASSB = 2'b10;

    localparam logic [1:0] WB_MEM = 2'b00;
    localparam logic [1:0] WB_ALU = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

    localparam logic [3:0] LT_BYTE = 4'b0001;
    localparam logic [3:0] LT_HALF = 4'b0011;
    localparam logic [3:0] LT_WORD = 4'b1111;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    state_t                 state;
    logic [31:0]            ir_q;
    logic                   reg_wen_q;
    logic                   mem_rw_q;
    logic                   pc_en_q;
    logic                   illegal_q;
    logic [INSTRET_W-1:0]   instret_q;

    logic [6:0]             opcode;
    logic [2:0]             funct3;
    logic                   is_load;
    logic                   is_store;
    logic                   is_branch;
    logic                   is_jump;
    logic                   dec_illegal;
    logic                   branch_taken;
    logic                   active;

    logic [3:0]             d_imm;
    logic                   d_brun;
    logic                   d_asel;
    logic                   d_bsel;
    logic [1:0]             d_alu;
    logic                   d_lui;
    logic [3:0]             d_lt;
    logic                   d_ls;
    logic [1:0]             d_wb;

    // Register/immediate fields are consumed by the datapath, not by control.
    logic                   unused_fields;
    assign unused_fields = ^{ir_q[31:15], ir_q[11:7]};

    assign opcode = ir_q[6:0];
    assign funct3 = ir_q[14:12];

    // Classify the latched instruction and derive its static controls.
    always_comb begin
        is_load     = 1'b0;
        is_store    = 1'b0;
        is_branch   = 1'b0;
        is_jump     = 1'b0;
        dec_illegal = 1'b0;
        d_imm       = IMM_I;
        d_brun      = 1'b0;
        d_asel      = 1'b0;
        d_bsel      = 1'b0;
        d_alu       = ALU_ADD;
        d_lui       = 1'b0;
        d_lt        = 4'b0000;
        d_ls        = 1'b0;
        d_wb        = WB_MEM;
        case (opcode)
            OPC_OP: begin
                d_alu = ALU_FUNCT;
                d_wb  = WB_ALU;
            end
            OPC_OPIMM: begin
                d_imm  = IMM_I;
                d_bsel = 1'b1;
                d_alu  = ALU_FUNCT;
                d_wb   = WB_ALU;
            end
            OPC_LUI: begin
                d_imm  = IMM_U;
                d_bsel = 1'b1;
                d_alu  = ALU_PASSB;
                d_lui  = 1'b1;
                d_wb   = WB_ALU;
            end
            OPC_AUIPC: begin
                d_imm  = IMM_U;
                d_asel = 1'b1;
                d_bsel = 1'b1;
                d_alu  = ALU_ADD;
                d_wb   = WB_ALU;
            end
            OPC_JAL: begin
                is_jump = 1'b1;
                d_imm   = IMM_J;
                d_asel  = 1'b1;
                d_bsel  = 1'b1;
                d_alu   = ALU_ADD;
                d_wb    = WB_PC4;
            end
            OPC_JALR: begin
                is_jump = 1'b1;
                d_imm   = IMM_I;
                d_bsel  = 1'b1;
                d_alu   = ALU_ADD;
                d_wb    = WB_PC4;
            end
            OPC_LOAD: begin
                is_load = 1'b1;
                d_imm   = IMM_I;
                d_bsel  = 1'b1;
                d_alu   = ALU_ADD;
                d_wb    = WB_MEM;
                case (funct3)
                    3'b000:  begin d_lt = LT_BYTE; d_ls = 1'b1; end
                    3'b001:  begin d_lt = LT_HALF; d_ls = 1'b1; end
                    3'b010:  begin d_lt = LT_WORD; d_ls = 1'b1; end
                    3'b100:  d_lt = LT_BYTE;
                    3'b101:  d_lt = LT_HALF;
                    default: dec_illegal = 1'b1;
                endcase
            end
            OPC_STORE: begin
                is_store = 1'b1;
                d_imm    = IMM_S;
                d_bsel   = 1'b1;
                d_alu    = ALU_ADD;
                case (funct3)
                    3'b000:  d_lt = LT_BYTE;
                    3'b001:  d_lt = LT_HALF;
                    3'b010:  d_lt = LT_WORD;
                    default: dec_illegal = 1'b1;
                endcase
            end
            OPC_BRANCH: begin
                is_branch = 1'b1;
                d_imm     = IMM_B;
                d_asel    = 1'b1;
                d_bsel    = 1'b1;
                d_alu     = ALU_ADD;
                d_brun    = (funct3[2:1] == 2'b11);
                if (funct3[2:1] == 2'b01) begin
                    dec_illegal = 1'b1;
                end
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    // Branch resolution from the live compare flags of the datapath.
    always_comb begin
        branch_taken = 1'b0;
        case (funct3)
            3'b000:  branch_taken = BrEQ;
            3'b001:  branch_taken = !BrEQ;
            3'b100:  branch_taken = BrLT;
            3'b101:  branch_taken = !BrLT;
            3'b110:  branch_taken = BrLT;
            3'b111:  branch_taken = !BrLT;
            default: branch_taken = 1'b0;
        endcase
    end

    // Sequencer: state, instruction latch, qualified pulses, trap and retire count.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state     <= S_FETCH;
            reg_wen_q <= 1'b0;
            mem_rw_q  <= 1'b0;
            pc_en_q   <= 1'b0;
            illegal_q <= 1'b0;
            instret_q <= '0;
        end else begin
            reg_wen_q <= 1'b0;
            mem_rw_q  <= 1'b0;
            pc_en_q   <= 1'b0;
            if (pc_en_q) begin
                instret_q <= instret_q + INSTRET_W'(1);
            end
            case (state)
                S_FETCH: begin
                    if (i_fetch_ack) begin
                        ir_q  <= instr;
                        state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (dec_illegal) begin
                        illegal_q <= 1'b1;
                        if (HALT_ON_ILLEGAL) begin
                            state <= S_HALT;
                        end else begin
                            // Retire as a NOP: PC advances, nothing is written.
                            state   <= S_WB;
                            pc_en_q <= 1'b1;
                        end
                    end else begin
                        state <= S_EXEC;
                        // Branches retire in EXEC, so the PC pulse is armed now.
                        if (is_branch) begin
                            pc_en_q <= 1'b1;
                        end
                    end
                end
                S_EXEC: begin
                    if (is_branch) begin
                        state <= S_FETCH;
                    end else if (is_load || is_store) begin
                        state <= S_MEM;
                        if (is_store) begin
                            mem_rw_q <= 1'b1;
                            pc_en_q  <= 1'b1;
                        end
                    end else begin
                        state     <= S_WB;
                        reg_wen_q <= 1'b1;
                        pc_en_q   <= 1'b1;
                    end
                end
                S_MEM: begin
                    if (is_store) begin
                        state <= S_FETCH;
                    end else begin
                        state     <= S_WB;
                        reg_wen_q <= 1'b1;
                        pc_en_q   <= 1'b1;
                    end
                end
                S_WB:    state <= S_FETCH;
                S_HALT:  state <= S_HALT;
                default: state <= S_FETCH;
            endcase
        end
    end

    // Static controls are only presented while an instruction is in flight.
    assign active = !i_reset && !dec_illegal &&
                    (state == S_DECODE || state == S_EXEC ||
                     state == S_MEM    || state == S_WB);

    assign ImmSel     = active ? d_imm  : 4'b0000;
    assign BrUn       = active ? d_brun : 1'b0;
    assign ASel       = active ? d_asel : 1'b0;
    assign BSel       = active ? d_bsel : 1'b0;
    assign ALU_op     = active ? d_alu  : 2'b00;
    assign LUI_Sel    = active ? d_lui  : 1'b0;
    assign LoadType   = active ? d_lt   : 4'b0000;
    assign LoadSigned = active ? d_ls   : 1'b0;
    assign WBSel      = active ? d_wb   : 2'b00;

    // Reset masks every output combinationally so an aborted pulse never escapes.
    assign o_fetch_req = !i_reset && (state == S_FETCH);
    assign RegWen      = !i_reset && reg_wen_q;
    assign MemRW       = !i_reset && mem_rw_q;
    assign o_pc_en     = !i_reset && pc_en_q;
    assign o_illegal   = !i_reset && illegal_q;
    assign o_instret   = i_reset ? '0 : instret_q;

    assign PCSel = o_pc_en &&
                   ((state == S_WB   && is_jump) ||
                    (state == S_EXEC && is_branch && branch_taken));

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed testbench for mc_ctrl_fsm: per-instruction pulse timing, static
// controls, fetch wait states, illegal trap and reset abort.
module tb_mc_ctrl_fsm;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic [31:0] instr;
    logic        BrEQ, BrLT, i_fetch_ack;
    logic        o_fetch_req, o_pc_en, PCSel, RegWen, BrUn, ASel, BSel;
    logic        LUI_Sel, LoadSigned, MemRW, o_illegal;
    logic [3:0]  ImmSel, LoadType;
    logic [1:0]  ALU_op, WBSel;
    logic [31:0] o_instret;

    int passed = 0;
    int total  = 0;

    logic [31:0] fetch_m, regwen_m, memrw_m, pcen_m, pcsel_m;
    logic [16:0] st_dec, st_ret;
    logic [16:0] st_obs;

    assign st_obs = {ImmSel, BrUn, ASel, BSel, ALU_op, LUI_Sel, LoadType, LoadSigned, WBSel};

    mc_ctrl_fsm #(.INSTRET_W(32), .HALT_ON_ILLEGAL(1'b1)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .instr(instr), .BrEQ(BrEQ), .BrLT(BrLT),
        .i_fetch_ack(i_fetch_ack), .o_fetch_req(o_fetch_req), .o_pc_en(o_pc_en),
        .PCSel(PCSel), .ImmSel(ImmSel), .RegWen(RegWen), .BrUn(BrUn), .ASel(ASel),
        .BSel(BSel), .ALU_op(ALU_op), .LUI_Sel(LUI_Sel), .LoadType(LoadType),
        .LoadSigned(LoadSigned), .MemRW(MemRW), .WBSel(WBSel), .o_illegal(o_illegal),
        .o_instret(o_instret)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // {ImmSel, BrUn, ASel, BSel, ALU_op, LUI_Sel, LoadType, LoadSigned, WBSel}
    function automatic logic [16:0] st(input logic [3:0] imm, input logic brun, input logic asel,
                                       input logic bsel, input logic [1:0] alu, input logic lui,
                                       input logic [3:0] lt, input logic ls, input logic [1:0] wb);
        return {imm, brun, asel, bsel, alu, lui, lt, ls, wb};
    endfunction

    // Feed one instruction: ack after `waits` idle FETCH cycles, then scramble
    // instr so only the latched copy can drive decode. Records ncyc cycles
    // (bit n-1 = cycle n) and ends at the start of the following cycle.
    task automatic run(input logic [31:0] word, input int waits, input int ncyc);
        fetch_m = '0; regwen_m = '0; memrw_m = '0; pcen_m = '0; pcsel_m = '0;
        st_dec = '0; st_ret = '0;
        for (int k = 0; k < ncyc; k++) begin
            i_fetch_ack = (k == waits);
            instr       = (k <= waits) ? word : ~word;
            #1;
            fetch_m[k]  = o_fetch_req;
            regwen_m[k] = RegWen;
            memrw_m[k]  = MemRW;
            pcen_m[k]   = o_pc_en;
            pcsel_m[k]  = PCSel;
            if (k == waits + 1) st_dec = st_obs;
            if (k == ncyc - 1)  st_ret = st_obs;
            @(posedge i_clk); #1;
        end
        i_fetch_ack = 1'b0;
    endtask

    initial begin
        i_reset = 1'b1; instr = 32'h0; BrEQ = 1'b0; BrLT = 1'b0; i_fetch_ack = 1'b1;

        // Reset state
        @(posedge i_clk); #1;
        @(posedge i_clk); #1;
        chk("rst_fetch_req", o_fetch_req, 0);
        chk("rst_pulses", {RegWen, MemRW, o_pc_en, PCSel}, 0);
        chk("rst_instret", o_instret, 0);
        chk("rst_illegal", o_illegal, 0);
        chk("rst_static", st_obs, 0);
        @(posedge i_clk); #1;
        i_reset = 1'b0; i_fetch_ack = 1'b0;

        // ADDI x1,x0,10
        run(32'h00A00093, 0, 4);
        chk("addi_fetch", fetch_m, 32'h1);
        chk("addi_regwen", regwen_m, 32'h8);
        chk("addi_pcen", pcen_m, 32'h8);
        chk("addi_memrw", memrw_m, 0);
        chk("addi_pcsel", pcsel_m, 0);
        chk("addi_st_dec", st_dec, st(4'b0000,0,0,1,2'b01,0,4'b0000,0,2'b01));
        chk("addi_st_ret", st_ret, st(4'b0000,0,0,1,2'b01,0,4'b0000,0,2'b01));
        chk("addi_instret", o_instret, 1);

        // SH x14,0(x12)
        run(32'h00E61023, 0, 4);
        chk("sh_memrw", memrw_m, 32'h8);
        chk("sh_pcen", pcen_m, 32'h8);
        chk("sh_regwen", regwen_m, 0);
        chk("sh_st_ret", st_ret, st(4'b0001,0,0,1,2'b00,0,4'b0011,0,2'b00));
        chk("sh_instret", o_instret, 2);

        // LH x15,0(x12)
        run(32'h00061783, 0, 5);
        chk("lh_regwen", regwen_m, 32'h10);
        chk("lh_pcen", pcen_m, 32'h10);
        chk("lh_memrw", memrw_m, 0);
        chk("lh_st_dec", st_dec, st(4'b0000,0,0,1,2'b00,0,4'b0011,1,2'b00));
        chk("lh_st_ret", st_ret, st(4'b0000,0,0,1,2'b00,0,4'b0011,1,2'b00));
        chk("lh_instret", o_instret, 3);

        // BEQ taken
        BrEQ = 1'b1;
        run(32'h00000463, 0, 3);
        chk("beq_t_pcen", pcen_m, 32'h4);
        chk("beq_t_pcsel", pcsel_m, 32'h4);
        chk("beq_t_regwen", regwen_m | memrw_m, 0);
        chk("beq_t_st_ret", st_ret, st(4'b0010,0,1,1,2'b00,0,4'b0000,0,2'b00));
        chk("beq_t_instret", o_instret, 4);

        // BEQ not taken
        BrEQ = 1'b0;
        run(32'h00000463, 0, 3);
        chk("beq_n_pcen", pcen_m, 32'h4);
        chk("beq_n_pcsel", pcsel_m, 0);
        chk("beq_n_instret", o_instret, 5);

        // BLTU taken, then BGEU not taken, both unsigned
        BrLT = 1'b1;
        run(32'h00006463, 0, 3);
        chk("bltu_pcsel", pcsel_m, 32'h4);
        chk("bltu_st_ret", st_ret, st(4'b0010,1,1,1,2'b00,0,4'b0000,0,2'b00));
        run(32'h00007463, 0, 3);
        chk("bgeu_pcsel", pcsel_m, 0);
        chk("bgeu_brun", st_ret[12], 1);
        BrLT = 1'b0;
        chk("bgeu_instret", o_instret, 7);

        // JAL x1,8
        run(32'h008000EF, 0, 4);
        chk("jal_regwen", regwen_m, 32'h8);
        chk("jal_pcsel", pcsel_m, 32'h8);
        chk("jal_st_ret", st_ret, st(4'b0100,0,1,1,2'b00,0,4'b0000,0,2'b10));

        // LUI x1,0x12345
        run(32'h123450B7, 0, 4);
        chk("lui_regwen", regwen_m, 32'h8);
        chk("lui_st_ret", st_ret, st(4'b1000,0,0,1,2'b10,1,4'b0000,0,2'b01));
        chk("lui_instret", o_instret, 9);

        // ADDI with 3 fetch wait states
        run(32'h00A00093, 3, 7);
        chk("wait_fetch", fetch_m, 32'hF);
        chk("wait_regwen", regwen_m, 32'h40);
        chk("wait_pcen", pcen_m, 32'h40);
        chk("wait_st_ret", st_ret, st(4'b0000,0,0,1,2'b01,0,4'b0000,0,2'b01));
        chk("wait_instret", o_instret, 10);

        // Illegal opcode halts
        run(32'h00000000, 0, 22);
        chk("ill_fetch", fetch_m, 32'h1);
        chk("ill_pulses", regwen_m | memrw_m | pcen_m, 0);
        chk("ill_st", st_dec | st_ret, 0);
        chk("ill_flag", o_illegal, 1);
        chk("ill_instret", o_instret, 10);
        chk("ill_halt_nofetch", o_fetch_req, 0);
        i_reset = 1'b1; #1;
        chk("ill_rst_flag", o_illegal, 0);
        @(posedge i_clk); #1;
        i_reset = 1'b0; #1;
        chk("ill_rst_fetch", o_fetch_req, 1);
        chk("ill_rst_instret", o_instret, 0);
        chk("ill_rst_illegal", o_illegal, 0);

        // Reset during MEM of SH aborts the store
        instr = 32'h00E61023; i_fetch_ack = 1'b1;
        @(posedge i_clk); #1; i_fetch_ack = 1'b0; instr = 32'hFFFFFFFF;
        @(posedge i_clk); #1;
        @(posedge i_clk); #1;
        chk("abort_memrw_pre", MemRW, 1);
        i_reset = 1'b1; #1;
        chk("abort_memrw", MemRW, 0);
        chk("abort_pcen", o_pc_en, 0);
        @(posedge i_clk); #1;
        i_reset = 1'b0; #1;
        chk("abort_fetch", o_fetch_req, 1);
        chk("abort_instret", o_instret, 0);
        chk("abort_pulses", {RegWen, MemRW, o_pc_en}, 0);
        run(32'h00A00093, 0, 4);
        chk("restart_regwen", regwen_m, 32'h8);
        chk("restart_instret", o_instret, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: observed no finish, expected finish within 100000 time units");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
Multi-cycle control unit for the RV32I datapath. It takes the datapath's instruction word and branch flags and steps each instruction through FETCH/DECODE/EXEC/MEM/WB, driving every datapath control input. It replaces manual control stimulus: register writes, memory writes and PC updates become single-cycle qualified pulses. It also handles instruction-fetch wait states, traps illegal opcodes and counts retired instructions.

Parameters:
INSTRET_W, 32, width of retired-instruction counter
HALT_ON_ILLEGAL, 1, 1: illegal opcode enters HALT; 0: retire as NOP (PC advances, no writes)

Ports:
i_clk  in  1  clock
i_reset  in  1  synchronous active-high reset
instr  in  32  current instruction from datapath IMEM
BrEQ  in  1  branch compare equal
BrLT  in  1  branch compare less-than (per BrUn)
i_fetch_ack  in  1  IMEM: instr valid this cycle
o_fetch_req  out  1  high in FETCH
o_pc_en  out  1  PC register load pulse (retire)
PCSel  out  1  0: PC+4, 1: ALU result
ImmSel  out  4  0000 I, 0001 S, 0010 B, 0100 J, 1000 U
RegWen  out  1  regfile write pulse
BrUn  out  1  unsigned compare
ASel  out  1  0: rs1, 1: PC
BSel  out  1  0: rs2, 1: imm
ALU_op  out  2  00 add, 01 funct3/funct7 decode, 10 pass B (LUI)
LUI_Sel  out  1  high for LUI
LoadType  out  4  0001 byte, 0011 half, 1111 word
LoadSigned  out  1  sign-extend load
MemRW  out  1  DMEM write pulse
WBSel  out  2  00 mem, 01 ALU, 10 PC+4
o_illegal  out  1  sticky illegal-instruction flag
o_instret  out  INSTRET_W  retired count

Behaviour:
- Reset: state=FETCH on the next edge. All outputs 0 while i_reset is high; o_instret=0; o_illegal=0. Reset in any state aborts the instruction; no RegWen/MemRW/o_pc_en pulse may occur on or after the reset edge.
- States: FETCH, DECODE, EXEC, MEM, WB, HALT.
- FETCH: o_fetch_req=1. Stay while !i_fetch_ack. On ack, latch instr into ir_q and go to DECODE.
- All decode uses ir_q only; later changes to instr are ignored.
- DECODE: 1 cycle, classify opcode. Go to EXEC, or HALT if illegal.
- EXEC routing:
  - OP/OP-IMM/LUI/AUIPC/JAL/JALR -> WB.
  - LOAD/STORE -> MEM.
  - BRANCH retires in EXEC: o_pc_en=1, PCSel=taken, then FETCH.
- Branch taken by funct3:
  - 000: BrEQ; 001: !BrEQ.
  - 100: BrLT; 101: !BrLT.
  - 110: BrLT, BrUn=1; 111: !BrLT, BrUn=1.
  - 010/011 are illegal.
- MEM:
  - STORE: MemRW=1 for exactly 1 cycle, o_pc_en=1, then FETCH.
  - LOAD: MemRW=0, then WB.
- WB: RegWen=1 and o_pc_en=1 for exactly 1 cycle, then FETCH. PCSel=1 only for JAL/JALR.
- Static controls from ir_q, held constant DECODE through the retire cycle:
  - OP: BSel=0, ALU_op=01, WBSel=01.
  - OP-IMM: ImmSel=0000, BSel=1, ALU_op=01, WBSel=01.
  - LUI: ImmSel=1000, BSel=1, ALU_op=10, LUI_Sel=1, WBSel=01.
  - AUIPC: ImmSel=1000, ASel=1, BSel=1, ALU_op=00, WBSel=01.
  - LOAD: ImmSel=0000, BSel=1, ALU_op=00, WBSel=00, LoadType/LoadSigned from funct3 (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU).
  - STORE: ImmSel=0001, BSel=1, ALU_op=00, LoadType from funct3 (000/001/010).
  - BRANCH: ImmSel=0010, ASel=1, BSel=1, ALU_op=00.
  - JAL: ImmSel=0100, ASel=1, BSel=1, ALU_op=00, WBSel=10.
  - JALR: ImmSel=0000, BSel=1, ALU_op=00, WBSel=10.
- Illegal (unknown opcode, or bad funct3 for LOAD/STORE/BRANCH):
  - HALT_ON_ILLEGAL=1: o_illegal=1, enter HALT with all pulses 0; leave only via reset.
  - HALT_ON_ILLEGAL=0: take a WB-like cycle with RegWen=0, o_pc_en=1, PCSel=0; o_illegal still sets (sticky).
- o_instret increments by 1 on every o_pc_en cycle and wraps modulo 2^INSTRET_W.
- Latency with ack in first FETCH cycle: ALU/LUI/JAL 4 cycles, LOAD 5, STORE 4, BRANCH 3. Each fetch-wait cycle adds 1.
- At most one of {RegWen, MemRW} is high in any cycle. o_pc_en is high exactly once per retired instruction.

Test Plan:
- ADDI x1,x0,10 (0x00A00093), ack immediate -> cycle 4: RegWen=1, o_pc_en=1, WBSel=01, BSel=1, ImmSel=0000, ALU_op=01; o_instret 0->1.
- SH x14,0(x12) (0x00E61023) then LH x15,0(x12) (0x00061783):
  - SH: MemRW=1 only in cycle 4, LoadType=0011, RegWen never high.
  - LH: RegWen in its cycle 5, WBSel=00, LoadSigned=1, LoadType=0011.
- BEQ x0,x0,8 (0x00000463):
  - BrEQ=1 -> cycle 3: o_pc_en=1, PCSel=1, ImmSel=0010.
  - Repeat with BrEQ=0 -> PCSel=0.
  - BLTU -> BrUn=1.
- i_fetch_ack held low 3 cycles -> o_fetch_req high 4 cycles; instr changes after ack do not alter the controls; ADDI retires at cycle 7.
- instr=0x00000000 with HALT_ON_ILLEGAL=1 -> o_illegal=1, state HALT, no pulses for 20 cycles; i_reset for 1 cycle -> FETCH, o_illegal=0, o_instret=0.
- i_reset asserted during MEM of SH -> MemRW=0 on that edge, o_instret unchanged; restart from FETCH.
